// File: rtl/synth_mat_pkg.sv
// Shared types and constants for the modulation/feedback coefficient matrix writer.
package synth_mat_pkg;

   localparam int unsigned MAT_DW      = 8;
   localparam int unsigned MAT_V_OSC   = 4;
   localparam int unsigned MAT_ROWS    = 16;
   localparam int unsigned MAT_FB_BASE = 8;

   typedef logic signed [MAT_DW-1:0] mat_coef_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACK   = 2'd1,
      CLEAR = 2'd2
   } mat_wr_state_t;

endpackage

// File: rtl/mod_matrix_writer_if.sv
// Control-path bundle between the parameter/MIDI writer and mod_matrix_writer.
interface mod_matrix_writer_if #(
   parameter int unsigned V_OSC = 4,
   parameter int unsigned ROWS  = 16,
   parameter int unsigned DW    = 8,
   parameter int unsigned CW    = $clog2(V_OSC),
   parameter int unsigned RW    = $clog2(ROWS)
);
   logic                               frame_strobe;
   logic                               wr_req;
   logic [RW-1:0]                      wr_row;
   logic [CW-1:0]                      wr_col;
   logic [DW-1:0]                      wr_data;
   logic                               clr_req;
   logic                               wr_ack;
   logic [RW-1:0]                      rd_row;
   logic [CW-1:0]                      rd_col;
   logic [DW-1:0]                      rd_data;
   logic                               busy;
   logic                               pending;
   logic [ROWS-1:0][V_OSC-1:0][DW-1:0] mat_buf;

   modport master (
      output frame_strobe, wr_req, wr_row, wr_col, wr_data, clr_req, rd_row, rd_col,
      input  wr_ack, rd_data, busy, pending, mat_buf
   );

   modport slave (
      input  frame_strobe, wr_req, wr_row, wr_col, wr_data, clr_req, rd_row, rd_col,
      output wr_ack, rd_data, busy, pending, mat_buf
   );
endinterface

// File: rtl/mat_coef_slew.sv
// One-entry slew stepper: moves the active coefficient one LSB toward its target and
// flags whether the stepped value has arrived.
module mat_coef_slew #(
   parameter int unsigned DW = 8
) (
   input  logic signed [DW-1:0] i_cur,
   input  logic signed [DW-1:0] i_tgt,
   output logic signed [DW-1:0] o_next,
   output logic                 o_match
);
   always_comb begin
      o_next = i_cur;
      if (i_cur < i_tgt) begin
         o_next = i_cur + DW'(1);
      end else if (i_cur > i_tgt) begin
         o_next = i_cur - DW'(1);
      end
      o_match = (o_next == i_tgt);
   end
endmodule

// File: rtl/mod_matrix_writer.sv
// Shadow/active coefficient matrix with frame-synchronous publish.
// Define MOD_MATRIX_SLEW_EN to slew active entries by one LSB per frame instead of jumping.
module mod_matrix_writer
   import synth_mat_pkg::*;
#(
   parameter int unsigned V_OSC = MAT_V_OSC,
   parameter int unsigned ROWS  = MAT_ROWS,
   parameter int unsigned DW    = MAT_DW,
   parameter int unsigned CW    = $clog2(V_OSC),
   parameter int unsigned RW    = $clog2(ROWS)
) (
   input logic              sCLK_XVXENVS,
   input logic              reset_reg_N,
   mod_matrix_writer_if.slave bus
);
   localparam int unsigned NENT = ROWS * V_OSC;

   mat_wr_state_t                      r_state, w_state_d;
   logic [RW+CW-1:0]                   r_cnt;
   logic [ROWS-1:0][V_OSC-1:0][DW-1:0] r_shadow;
   logic [ROWS-1:0][V_OSC-1:0][DW-1:0] r_mat;
   logic [ROWS-1:0][V_OSC-1:0][DW-1:0] w_mat_next;
   logic                               r_dirty;
   logic [DW-1:0]                      r_rd_data;
   logic                               w_wr_en;
   logic                               w_clr_done;
   logic                               w_commit;
   logic                               w_all_match;
   logic [RW-1:0]                      w_clr_row;
   logic [CW-1:0]                      w_clr_col;

   assign w_clr_row  = r_cnt[RW+CW-1:CW];
   assign w_clr_col  = r_cnt[CW-1:0];
   assign w_clr_done = (r_state == CLEAR) && (r_cnt == (RW+CW)'(NENT - 1));
   // A strobe landing inside a clear sweep is dropped; the next one publishes.
   assign w_commit   = bus.frame_strobe && r_dirty && (r_state != CLEAR);

   always_comb begin
      w_state_d = r_state;
      w_wr_en   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.clr_req) begin
               w_state_d = CLEAR;
            end else if (bus.wr_req) begin
               w_state_d = ACK;
               w_wr_en   = 1'b1;
            end
         end
         ACK:     w_state_d = IDLE;
         CLEAR:   if (w_clr_done) w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

`ifdef MOD_MATRIX_SLEW_EN
   logic [NENT-1:0] w_match;

   for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      for (genvar gc = 0; gc < V_OSC; gc++) begin : g_col
         mat_coef_slew #(
            .DW (DW)
         ) u_slew (
            .i_cur   (r_mat[gr][gc]),
            .i_tgt   (r_shadow[gr][gc]),
            .o_next  (w_mat_next[gr][gc]),
            .o_match (w_match[gr*V_OSC + gc])
         );
      end
   end

   assign w_all_match = &w_match;
`else
   assign w_mat_next  = r_shadow;
   assign w_all_match = 1'b1;
`endif

   always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_shadow  <= '0;
         r_mat     <= '0;
         r_dirty   <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_state   <= w_state_d;
         r_rd_data <= r_shadow[bus.rd_row][bus.rd_col];
         // Commit reads the pre-edge shadow, so a same-cycle write waits for the next strobe.
         if (w_commit) begin
            r_mat <= w_mat_next;
         end
         if (r_state == CLEAR) begin
            r_shadow[w_clr_row][w_clr_col] <= '0;
            r_cnt                          <= r_cnt + (RW+CW)'(1);
         end else begin
            r_cnt <= '0;
         end
         if (w_wr_en) begin
            r_shadow[bus.wr_row][bus.wr_col] <= bus.wr_data;
         end
         if (w_wr_en || w_clr_done) begin
            r_dirty <= 1'b1;
         end else if (w_commit && w_all_match) begin
            r_dirty <= 1'b0;
         end
      end
   end

   assign bus.wr_ack  = (r_state == ACK);
   assign bus.busy    = (r_state == CLEAR);
   assign bus.pending = r_dirty;
   assign bus.rd_data = r_rd_data;
   assign bus.mat_buf = r_mat;

endmodule
